// File: rtl/spa_ctrl_pkg.sv
// Shared types for the SPA capture controller: FSM state encoding and default
// counter width.
package spa_ctrl_pkg;

  localparam int CNT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH_RO  = 3'd1,
    ST_DELAY      = 3'd2,
    ST_LAUNCH_RSA = 3'd3,
    ST_WAIT       = 3'd4,
    ST_DONE       = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  // A run is in progress in every state other than IDLE, DONE and FAULT.
  function automatic logic state_busy(input state_e s);
    return (s == ST_LAUNCH_RO) || (s == ST_DELAY) ||
           (s == ST_LAUNCH_RSA) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter; holds at zero and flags it.
module down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/spa_capture_ctrl.sv
// Sequences one SPA capture: launch the RO sampler, wait a programmable delay,
// launch the RSA core, then wait for both to finish or for the run to time out.
module spa_capture_ctrl
  import spa_ctrl_pkg::*;
#(
  parameter int SIZE_WIDTH = 32,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SIZE_WIDTH-1:0] delay_cycles,
  input  logic [SIZE_WIDTH-1:0] timeout_cycles,
  output logic                  ro_go,
  output logic                  rsa_go,
  input  logic                  ro_done,
  input  logic                  rsa_done,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  run_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_r, state_nx_s;
  logic [CNT_WIDTH-1:0] timeout_r, run_cycles_r, run_inc_s;
  logic                 ro_seen_r, rsa_seen_r;
  logic                 start_ok_s, timeout_hit_s, dly_en_s, dly_zero_s, rsa_window_s;
  logic                 ro_go_nx_s, rsa_go_nx_s, busy_nx_s, done_nx_s, fault_nx_s;
  logic                 ro_go_r, rsa_go_r, busy_r, done_r, fault_r;

  assign start_ok_s   = start && !abort && !state_busy(state_r);
  assign dly_en_s     = (state_r == ST_LAUNCH_RO) || (state_r == ST_DELAY);
  assign rsa_window_s = (state_r == ST_LAUNCH_RSA) || (state_r == ST_WAIT);
  assign run_inc_s    = (&run_cycles_r) ? run_cycles_r : run_cycles_r + CNT_ONE;
  // Timeout looks at the next count so FAULT coincides with run_cycles == T.
  assign timeout_hit_s = (timeout_r != CNT_ZERO) && (run_inc_s >= timeout_r);

  down_counter #(.WIDTH(CNT_WIDTH)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok_s),
    .load_val (CNT_WIDTH'(delay_cycles)),
    .en       (dly_en_s),
    .zero     (dly_zero_s)
  );

  // State and decoded output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ro_go_r  <= 1'b0;
      rsa_go_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      ro_go_r  <= ro_go_nx_s;
      rsa_go_r <= rsa_go_nx_s;
      busy_r   <= busy_nx_s;
      done_r   <= done_nx_s;
      fault_r  <= fault_nx_s;
    end
  end

  // Next-state logic; abort overrides everything, completion beats timeout.
  always_comb begin
    state_nx_s = ST_IDLE;
    if (abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) state_nx_s = ST_LAUNCH_RO;
          else       state_nx_s = state_r;
        end
        ST_LAUNCH_RO, ST_DELAY: begin
          if (timeout_hit_s)   state_nx_s = ST_FAULT;
          else if (dly_zero_s) state_nx_s = ST_LAUNCH_RSA;
          else                 state_nx_s = ST_DELAY;
        end
        ST_LAUNCH_RSA: begin
          if (timeout_hit_s) state_nx_s = ST_FAULT;
          else               state_nx_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (ro_seen_r && rsa_seen_r) state_nx_s = ST_DONE;
          else if (timeout_hit_s)      state_nx_s = ST_FAULT;
          else                         state_nx_s = ST_WAIT;
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    ro_go_nx_s  = (state_nx_s == ST_LAUNCH_RO);
    rsa_go_nx_s = (state_nx_s == ST_LAUNCH_RSA);
    busy_nx_s   = state_busy(state_nx_s);
    done_nx_s   = (state_nx_s == ST_DONE);
    fault_nx_s  = (state_nx_s == ST_FAULT);
  end

  // Latched timeout and the saturating run-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r    <= CNT_ZERO;
      run_cycles_r <= CNT_ZERO;
    end else if (start_ok_s) begin
      timeout_r    <= CNT_WIDTH'(timeout_cycles);
      run_cycles_r <= CNT_ZERO;
    end else if (state_busy(state_r)) begin
      run_cycles_r <= run_inc_s;
    end else begin
      run_cycles_r <= run_cycles_r;
    end
  end

  // Sticky completion flags, so done inputs may be pulses or levels in any order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_seen_r  <= 1'b0;
      rsa_seen_r <= 1'b0;
    end else if (start_ok_s || abort) begin
      ro_seen_r  <= 1'b0;
      rsa_seen_r <= 1'b0;
    end else begin
      ro_seen_r  <= ro_seen_r  | (ro_done  & state_busy(state_r));
      rsa_seen_r <= rsa_seen_r | (rsa_done & rsa_window_s);
    end
  end

  assign ro_go      = ro_go_r;
  assign rsa_go     = rsa_go_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fault      = fault_r;
  assign run_cycles = run_cycles_r;

endmodule

// File: doc/spa_capture_ctrl.md
SPA_CAPTURE_CTRL -- requirements
Module: spa_capture_ctrl

Interface
REQ-001 Parameter SIZE_WIDTH, default 32: width of the delay_cycles and timeout_cycles configuration inputs.
REQ-002 Parameter CNT_WIDTH, default 32: width of the internal delay and timeout counters; SHALL be >= SIZE_WIDTH.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin one capture run.
REQ-006 abort  input  1  cancels the run in progress; level or pulse.
REQ-007 delay_cycles  input  SIZE_WIDTH  cycles from the RO launch to the RSA launch.
REQ-008 timeout_cycles  input  SIZE_WIDTH  run limit in cycles; 0 disables the timeout.
REQ-009 ro_go  output  1  one-cycle launch pulse to the ring-oscillator sampler.
REQ-010 rsa_go  output  1  one-cycle launch pulse to the RSA core.
REQ-011 ro_done  input  1  sampler completion; level or pulse.
REQ-012 rsa_done  input  1  RSA completion; level or pulse.
REQ-013 busy  output  1  high in every state except IDLE, DONE and FAULT.
REQ-014 done  output  1  run completed; held until the next start, abort or reset.
REQ-015 fault  output  1  run timed out; held until the next start, abort or reset.
REQ-016 run_cycles  output  CNT_WIDTH  cycle count of the last or current run.

Function
REQ-017 The FSM states SHALL be IDLE, LAUNCH_RO, DELAY, LAUNCH_RSA, WAIT, DONE and FAULT.
REQ-018 When start is high in IDLE, DONE or FAULT, the block SHALL latch delay_cycles and timeout_cycles, clear done, fault, run_cycles and both sticky done flags, and enter LAUNCH_RO.
REQ-019 start SHALL be ignored while busy.
REQ-020 ro_go SHALL be high exactly in the LAUNCH_RO cycle, i.e. the first cycle after the start cycle; the next state SHALL be DELAY, or LAUNCH_RSA if the latched delay is 0.
REQ-021 DELAY SHALL last exactly the latched delay D cycles, so rsa_go is high in cycle 2+D, counting the start cycle as cycle 0.
REQ-022 rsa_go SHALL be high exactly in the LAUNCH_RSA cycle; the next state SHALL be WAIT.
REQ-023 Sticky flag ro_seen SHALL set on any cycle with ro_done high from LAUNCH_RO onward, including during DELAY; rsa_seen SHALL set on any cycle with rsa_done high from LAUNCH_RSA onward.
REQ-024 WAIT SHALL go to DONE in the cycle after both sticky flags are set; completion order SHALL not matter.
REQ-025 Done inputs asserted in IDLE, DONE or FAULT SHALL be ignored.
REQ-026 run_cycles SHALL increment by 1 per busy cycle and saturate at all-ones; it SHALL freeze in DONE and FAULT.
REQ-027 If the latched timeout T is nonzero and run_cycles reaches T while busy, the next state SHALL be FAULT; if completion and timeout fall in the same cycle, completion (DONE) SHALL win.
REQ-028 abort high in any state SHALL force IDLE on the next edge, clear done and fault, and suppress any ro_go or rsa_go pulse in that cycle and after it.
REQ-029 abort and start in the same cycle: abort SHALL win.
REQ-030 ro_go and rsa_go SHALL never be high in the same cycle, and each SHALL pulse at most once per run.

Reset
REQ-031 While rst is high, the state SHALL be IDLE and ro_go, rsa_go, busy, done and fault SHALL be 0.
REQ-032 While rst is high, run_cycles, the latched configuration and the sticky flags SHALL be 0.
REQ-033 Reset asserted mid-run SHALL abandon the run with no further go pulses after rst is released.

Structure
REQ-034 The state enum and the CNT_WIDTH default SHALL live in a shared package, spa_ctrl_pkg.
REQ-035 The delay counter SHALL be one sub-module, down_counter, with load, enable and zero outputs.
REQ-036 All outputs SHALL be decoded from registered state and counters, with no combinational path from any input to any output.

Verification
REQ-037 D=3, T=0; ro_done at cycle 10 and rsa_done at cycle 20 -> ro_go at cycle 1, rsa_go at cycle 5, done=1 from cycle 22.
REQ-038 D=0 -> ro_go at cycle 1 and rsa_go at cycle 2; rsa_done arriving before ro_done still gives done.
REQ-039 D=2, T=50, rsa_done never asserted -> fault=1 and busy=0 at cycle 51, run_cycles=50, done=0.
REQ-040 abort at cycle 3 with D=5 -> state IDLE at cycle 4, no rsa_go pulse, done=0 and fault=0.
REQ-041 Second start at cycle 2, then a restart from DONE -> second start ignored; restart clears done and produces a new ro_go one cycle later.
REQ-042 rst pulsed during WAIT -> all outputs 0, and no go pulse after rst is released.
